// File: rtl/imem_access_arbiter.sv
// rtl/imem_access_arbiter.sv - instruction RAM owner: boot sequencing, fetch/loader arbitration, NOP substitution
//
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   boot_mode                1: stay in LOAD until l_done; 0: go straight to RUN
//   f_req/f_addr             fetch request and byte address
//   f_gnt                    fetch accepted this cycle (combinational)
//   f_rvalid/f_rdata/f_err   fetch response, one cycle after f_gnt
//   l_req/l_addr/l_wdata     loader write request, byte address and data
//   l_gnt                    write accepted this cycle (combinational)
//   l_err                    pulse the cycle after an illegal write was granted
//   l_done                   loader finished
//   l_count                  legal words written since reset, saturating
//   core_stall               high while in LOAD
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   single-port synchronous RAM
module imem_access_arbiter #(
    parameter int          ADDR_W = 64,
    parameter int          DEPTH  = 1024,
    parameter logic [31:0] NOP    = 32'h00000033,
    parameter int          CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     boot_mode,
    input  logic                     f_req,
    input  logic [ADDR_W-1:0]        f_addr,
    output logic                     f_gnt,
    output logic                     f_rvalid,
    output logic [31:0]              f_rdata,
    output logic                     f_err,
    input  logic                     l_req,
    input  logic [ADDR_W-1:0]        l_addr,
    input  logic [31:0]              l_wdata,
    output logic                     l_gnt,
    output logic                     l_err,
    input  logic                     l_done,
    output logic [CNT_W-1:0]         l_count,
    output logic                     core_stall,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata
);

    localparam int MEM_AW = $clog2(DEPTH);

    // Full-width limit so high address bits can never alias into the RAM.
    localparam logic [ADDR_W-1:0] BYTE_LIMIT = ADDR_W'(4 * DEPTH);

    typedef enum logic {
        LOAD,
        RUN
    } state_t;

    typedef enum logic {
        W_LOADER,
        W_FETCH
    } winner_t;

    state_t  state;
    state_t  state_next;
    winner_t last_winner;

    logic        f_misaligned;
    logic        f_legal;
    logic        l_legal;
    logic        fetch_from_mem;  // a legal RAM read is returning this cycle
    logic [31:0] f_rdata_q;

    assign f_misaligned = (f_addr[1:0] != 2'b00);
    assign f_legal      = !f_misaligned && (f_addr < BYTE_LIMIT);
    assign l_legal      = (l_addr[1:0] == 2'b00) && (l_addr < BYTE_LIMIT);

    assign core_stall = (state == LOAD);

    // RAM data is only valid in the return cycle, so it is passed straight
    // through then and captured for the hold-last-value behaviour afterwards.
    assign f_rdata = fetch_from_mem ? mem_rdata : f_rdata_q;

    always_comb begin
        state_next = state;
        f_gnt      = 1'b0;
        l_gnt      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        if (!reset) begin
            case (state)
                LOAD: begin
                    l_gnt = l_req;
                    if (l_done || !boot_mode) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (f_req && l_req) begin
                        // Contended: the side that lost last time goes now.
                        if (last_winner == W_LOADER) begin
                            f_gnt = 1'b1;
                        end else begin
                            l_gnt = 1'b1;
                        end
                    end else begin
                        f_gnt = f_req;
                        l_gnt = l_req;
                    end
                end
                default: state_next = LOAD;
            endcase

            if (f_gnt && f_legal) begin
                mem_en   = 1'b1;
                mem_addr = f_addr[MEM_AW+1:2];
            end
            if (l_gnt && l_legal) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = l_addr[MEM_AW+1:2];
                mem_wdata = l_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= LOAD;
            last_winner    <= W_LOADER;
            fetch_from_mem <= 1'b0;
            f_rvalid       <= 1'b0;
            f_err          <= 1'b0;
            f_rdata_q      <= '0;
            l_err          <= 1'b0;
            l_count        <= '0;
        end else begin
            state <= state_next;

            if (state == RUN && f_req && l_req) begin
                last_winner <= f_gnt ? W_FETCH : W_LOADER;
            end

            f_rvalid       <= f_gnt;
            f_err          <= f_gnt && f_misaligned;
            fetch_from_mem <= f_gnt && f_legal;

            if (fetch_from_mem) begin
                f_rdata_q <= mem_rdata;
            end
            if (f_gnt && !f_legal) begin
                f_rdata_q <= NOP;
            end

            l_err <= l_gnt && !l_legal;

            if (l_gnt && l_legal && (l_count != {CNT_W{1'b1}})) begin
                l_count <= l_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// tb/tb_imem_access_arbiter.sv - directed self-checking bench for imem_access_arbiter
module tb_imem_access_arbiter;

    localparam int ADDR_W = 64;
    localparam int DEPTH  = 1000;
    localparam int CNT_W  = 16;
    localparam int MAW    = $clog2(DEPTH);

    logic              clk;
    logic              reset;
    logic              boot_mode;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [31:0]       f_rdata;
    logic              f_err;
    logic              l_req;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;
    logic              l_gnt;
    logic              l_err;
    logic              l_done;
    logic [CNT_W-1:0]  l_count;
    logic              core_stall;
    logic              mem_en;
    logic              mem_we;
    logic [MAW-1:0]    mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int checks = 0;
    int errors = 0;

    imem_access_arbiter #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NOP    (32'h00000033),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .boot_mode  (boot_mode),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_gnt      (f_gnt),
        .f_rvalid   (f_rvalid),
        .f_rdata    (f_rdata),
        .f_err      (f_err),
        .l_req      (l_req),
        .l_addr     (l_addr),
        .l_wdata    (l_wdata),
        .l_gnt      (l_gnt),
        .l_err      (l_err),
        .l_done     (l_done),
        .l_count    (l_count),
        .core_stall (core_stall),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM; reset fills word i with 0xA5000000 | i.
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram[i] <= 32'hA5000000 | 32'(i);
            end
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one uncontended fetch in RUN and check grant, RAM use and response.
    task automatic do_fetch(input string tag, input logic [63:0] a, input logic exp_en,
                            input logic [31:0] exp_data, input logic exp_err);
        f_req  = 1'b1;
        f_addr = a;
        #1;
        chk({tag, "_gnt"}, 64'(f_gnt), 64'd1);
        chk({tag, "_mem_en"}, 64'(mem_en), 64'(exp_en));
        tick();
        f_req = 1'b0;
        chk({tag, "_rvalid"}, 64'(f_rvalid), 64'd1);
        chk({tag, "_rdata"}, 64'(f_rdata), 64'(exp_data));
        chk({tag, "_err"}, 64'(f_err), 64'(exp_err));
    endtask

    initial begin
        reset     = 1'b1;
        boot_mode = 1'b1;
        f_req     = 1'b1;
        f_addr    = '0;
        l_req     = 1'b1;
        l_addr    = '0;
        l_wdata   = '0;
        l_done    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_f_gnt", 64'(f_gnt), 64'd0);
        chk("rst_l_gnt", 64'(l_gnt), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_f_rvalid", 64'(f_rvalid), 64'd0);
        chk("rst_f_rdata", 64'(f_rdata), 64'd0);
        chk("rst_f_err", 64'(f_err), 64'd0);
        chk("rst_l_err", 64'(l_err), 64'd0);
        chk("rst_l_count", 64'(l_count), 64'd0);
        chk("rst_core_stall", 64'(core_stall), 64'd1);

        // LOAD: eight legal writes while fetch is requesting.
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            l_req   = 1'b1;
            l_addr  = 64'(4 * i);
            l_wdata = (i == 1) ? 32'h00108093 : (32'h10000000 + 32'(i));
            #1;
            chk("load_l_gnt", 64'(l_gnt), 64'd1);
            chk("load_f_gnt", 64'(f_gnt), 64'd0);
            chk("load_mem_we", 64'(mem_we), 64'd1);
            chk("load_mem_addr", 64'(mem_addr), 64'(i));
            chk("load_mem_wdata", 64'(mem_wdata), 64'(l_wdata));
            chk("load_l_count", 64'(l_count), 64'(i));
            tick();
        end
        chk("load_l_count8", 64'(l_count), 64'd8);

        // Out-of-range write.
        l_addr = 64'h2710;
        #1;
        chk("oor_wr_gnt", 64'(l_gnt), 64'd1);
        chk("oor_wr_mem_en", 64'(mem_en), 64'd0);
        chk("oor_wr_f_gnt", 64'(f_gnt), 64'd0);
        tick();
        chk("oor_wr_l_err", 64'(l_err), 64'd1);
        chk("oor_wr_l_count", 64'(l_count), 64'd8);

        // Misaligned write.
        l_addr = 64'h2;
        #1;
        chk("mis_wr_gnt", 64'(l_gnt), 64'd1);
        chk("mis_wr_mem_en", 64'(mem_en), 64'd0);
        tick();
        chk("mis_wr_l_err", 64'(l_err), 64'd1);
        l_req = 1'b0;
        tick();
        chk("l_err_pulse_end", 64'(l_err), 64'd0);
        chk("l_count_after_bad", 64'(l_count), 64'd8);

        // l_done: stall drops one cycle later.
        f_req  = 1'b0;
        l_done = 1'b1;
        #1;
        chk("done_stall_same", 64'(core_stall), 64'd1);
        tick();
        l_done = 1'b0;
        chk("done_stall_next", 64'(core_stall), 64'd0);
        chk("done_l_count", 64'(l_count), 64'd8);

        // RUN: fetches.
        f_req  = 1'b1;
        f_addr = 64'h4;
        #1;
        chk("f4_gnt", 64'(f_gnt), 64'd1);
        chk("f4_l_gnt", 64'(l_gnt), 64'd0);
        chk("f4_mem_en", 64'(mem_en), 64'd1);
        chk("f4_mem_we", 64'(mem_we), 64'd0);
        chk("f4_mem_addr", 64'(mem_addr), 64'd1);
        tick();
        f_req = 1'b0;
        chk("f4_rvalid", 64'(f_rvalid), 64'd1);
        chk("f4_rdata", 64'(f_rdata), 64'h00108093);
        chk("f4_err", 64'(f_err), 64'd0);
        tick();
        chk("idle_rvalid", 64'(f_rvalid), 64'd0);
        chk("idle_rdata_hold", 64'(f_rdata), 64'h00108093);

        do_fetch("f_fa0", 64'hFA0, 1'b0, 32'h00000033, 1'b0);
        do_fetch("f_6", 64'h6, 1'b0, 32'h00000033, 1'b1);
        do_fetch("f_f9c", 64'hF9C, 1'b1, 32'hA50003E7, 1'b0);
        do_fetch("f_hi", 64'h1_0000_0000, 1'b0, 32'h00000033, 1'b0);
        do_fetch("f_0", 64'h0, 1'b1, 32'h10000000, 1'b0);
        tick();
        chk("hold_rvalid", 64'(f_rvalid), 64'd0);
        chk("hold_rdata", 64'(f_rdata), 64'h10000000);
        chk("hold_err", 64'(f_err), 64'd0);

        // Contention: round-robin starting with fetch.
        f_req  = 1'b1;
        f_addr = 64'h8;
        l_req  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            l_addr  = 64'(32 + 4 * i);
            l_wdata = 32'hC0DE0000 + 32'(i);
            #1;
            chk("rr_f_gnt", 64'(f_gnt), 64'((i % 2) == 0));
            chk("rr_l_gnt", 64'(l_gnt), 64'((i % 2) == 1));
            chk("rr_both", 64'(f_gnt & l_gnt), 64'd0);
            tick();
        end
        f_req = 1'b0;
        l_req = 1'b0;
        chk("rr_l_count", 64'(l_count), 64'd11);

        // Reset the cycle after a fetch grant.
        f_req  = 1'b1;
        f_addr = 64'h0;
        #1;
        chk("rf_gnt", 64'(f_gnt), 64'd1);
        tick();
        f_req = 1'b0;
        chk("rf_rvalid_pre", 64'(f_rvalid), 64'd1);
        reset = 1'b1;
        #1;
        chk("rf_rvalid", 64'(f_rvalid), 64'd0);
        chk("rf_stall", 64'(core_stall), 64'd1);
        chk("rf_l_count", 64'(l_count), 64'd0);
        chk("rf_rdata", 64'(f_rdata), 64'd0);

        // boot_mode=0 goes straight to RUN.
        tick();
        reset     = 1'b0;
        boot_mode = 1'b0;
        #1;
        chk("nb_stall_first", 64'(core_stall), 64'd1);
        tick();
        chk("nb_stall_next", 64'(core_stall), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
